// File: rtl/exa_crosb_pkg.sv
// ---------------------------------------------------------------------------
// exa_crosb_pkg
// Shared definitions for the crossbar output arbiter slice.
//   arb_state_t       : arbiter FSM state (IDLE waiting for requests, LOCK
//                       holding the mux for one packet)
//   DEFAULT_INPUT_NUM : default number of requesting inputs
//   clog2             : select width for a given input count (minimum 1)
// ---------------------------------------------------------------------------
package exa_crosb_pkg;

  localparam int DEFAULT_INPUT_NUM = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so a select port always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/exa_rr_pick.sv
// ---------------------------------------------------------------------------
// exa_rr_pick
// Combinational rotate-priority encoder. Returns the first set request bit
// scanning upward from i_ptr+1, wrapping modulo input_num.
// Ports:
//   i_req   [input_num]  request vector
//   i_ptr   [sel_width]  last winner (search starts one above it)
//   o_idx   [sel_width]  index of the selected request (0 when none)
//   o_found [1]          at least one request bit was set
// ---------------------------------------------------------------------------
module exa_rr_pick
  import exa_crosb_pkg::*;
#(
  parameter int input_num = DEFAULT_INPUT_NUM,
  parameter int sel_width = clog2(input_num)
) (
  input  logic [input_num-1:0] i_req,
  input  logic [sel_width-1:0] i_ptr,
  output logic [sel_width-1:0] o_idx,
  output logic                 o_found
);

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // the pointer overwrites any earlier candidate and ends up as the result.
  always_comb begin
    int j;
    logic [sel_width-1:0] w_cand;
    j       = 0;
    w_cand  = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = input_num; k >= 1; k--) begin
      j = int'(i_ptr) + k;
      if (j >= input_num) begin
        j = j - input_num;
      end
      w_cand = sel_width'(j);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/exa_crosb_out_arbiter.sv
// ---------------------------------------------------------------------------
// exa_crosb_out_arbiter
// Per-output-port packet arbiter for the crossbar. Picks a requesting input
// round-robin, drives the shared mux select and holds it for a whole packet,
// releasing only when the beat flagged last is accepted downstream.
// Ports:
//   clk          clock
//   reset        asynchronous reset, active-high
//   REQ_i        [input_num] per-input head-of-line request for this output
//   MUX_VALID_i  valid of the beat on the mux output
//   MUX_LAST_i   last flag of the beat on the mux output
//   OUT_READY_i  downstream accepts a beat this cycle
//   SEL_o        [sel_width] registered mux select
//   GRANT_o      [input_num] registered one-hot clear-to-send
//   BUSY_o       a packet is locked through the mux
//   PKT_CNT_o    [cnt_width] completed packet count, wraps
//   PRIO_i       [input_num] high-priority flags   (EXA_ARB_PRIO_EN only)
//   PRIO_o       priority of the granted input     (EXA_ARB_PRIO_EN only)
// Build option: define EXA_ARB_PRIO_EN to add priority-first arbitration.
// ---------------------------------------------------------------------------
module exa_crosb_out_arbiter
  import exa_crosb_pkg::*;
#(
  parameter int input_num = DEFAULT_INPUT_NUM,
  parameter int sel_width = clog2(input_num),
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [input_num-1:0] REQ_i,
  input  logic                 MUX_VALID_i,
  input  logic                 MUX_LAST_i,
  input  logic                 OUT_READY_i,
`ifdef EXA_ARB_PRIO_EN
  input  logic [input_num-1:0] PRIO_i,
  output logic                 PRIO_o,
`endif
  output logic [sel_width-1:0] SEL_o,
  output logic [input_num-1:0] GRANT_o,
  output logic                 BUSY_o,
  output logic [cnt_width-1:0] PKT_CNT_o
);

  arb_state_t           r_state;
  logic [sel_width-1:0] r_sel;
  logic [sel_width-1:0] r_rrPtr;
  logic [input_num-1:0] r_grant;
  logic                 r_busy;
  logic [cnt_width-1:0] r_pktCnt;

  logic [sel_width-1:0] w_winIdx;
  logic                 w_winFound;
  logic [input_num-1:0] w_grantNext;
  logic                 w_release;

`ifdef EXA_ARB_PRIO_EN
  logic                 r_prio;
  logic [input_num-1:0] w_hiReq;
  logic [sel_width-1:0] w_hiIdx;
  logic                 w_hiFound;
  logic [sel_width-1:0] w_allIdx;
  logic                 w_allFound;

  assign w_hiReq = REQ_i & PRIO_i;

  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pickHi (
    .i_req   (w_hiReq),
    .i_ptr   (r_rrPtr),
    .o_idx   (w_hiIdx),
    .o_found (w_hiFound)
  );

  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pickAll (
    .i_req   (REQ_i),
    .i_ptr   (r_rrPtr),
    .o_idx   (w_allIdx),
    .o_found (w_allFound)
  );

  // Any high-priority hit is also a plain request hit, so the plain found
  // flag alone tells whether a grant happens at all.
  assign w_winIdx   = w_hiFound ? w_hiIdx : w_allIdx;
  assign w_winFound = w_allFound;
  assign PRIO_o     = r_prio;
`else
  exa_rr_pick #(
    .input_num (input_num),
    .sel_width (sel_width)
  ) u_pick (
    .i_req   (REQ_i),
    .i_ptr   (r_rrPtr),
    .o_idx   (w_winIdx),
    .o_found (w_winFound)
  );
`endif

  assign w_grantNext = {{(input_num-1){1'b0}}, 1'b1} << w_winIdx;

  // A last flag only counts when the beat is actually handed downstream.
  assign w_release = MUX_VALID_i & OUT_READY_i & MUX_LAST_i;

  // IDLE registers a new winner; LOCK freezes select and grant until the
  // last beat goes out, then drops back to IDLE for a one-cycle bubble so
  // the pointer update is visible before the next pick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rrPtr  <= sel_width'(input_num - 1);
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_pktCnt <= '0;
`ifdef EXA_ARB_PRIO_EN
      r_prio   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_winFound) begin
            r_state <= LOCK;
            r_sel   <= w_winIdx;
            r_grant <= w_grantNext;
            r_busy  <= 1'b1;
`ifdef EXA_ARB_PRIO_EN
            r_prio  <= PRIO_i[w_winIdx];
`endif
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        LOCK: begin
          if (w_release) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rrPtr  <= r_sel;
            r_pktCnt <= r_pktCnt + cnt_width'(1);
`ifdef EXA_ARB_PRIO_EN
            r_prio   <= 1'b0;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SEL_o     = r_sel;
  assign GRANT_o   = r_grant;
  assign BUSY_o    = r_busy;
  assign PKT_CNT_o = r_pktCnt;

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exa_crosb_out_arbiter
// Self-checking bench for exa_crosb_out_arbiter (16 inputs). Directed
// scenarios plus a randomized run against a packet-level reference model.
// Define EXA_ARB_PRIO_EN for both bench and RTL to exercise priority mode.
// ---------------------------------------------------------------------------
module tb_exa_crosb_out_arbiter;

  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        muxValid;
  logic        muxLast;
  logic        outReady;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        busy;
  logic [31:0] pktCnt;
  logic [15:0] prioIn;
`ifdef EXA_ARB_PRIO_EN
  logic        prioOut;
`endif

  int checks;
  int errors;

  // Reference model: which input owns the output, who won last, packets done.
  bit          mBusy;
  int          mSel;
  int          mLast;
  logic [31:0] mCnt;
  bit          mPrio;

  exa_crosb_out_arbiter #(
    .input_num (N),
    .sel_width (4),
    .cnt_width (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .REQ_i       (req),
    .MUX_VALID_i (muxValid),
    .MUX_LAST_i  (muxLast),
    .OUT_READY_i (outReady),
`ifdef EXA_ARB_PRIO_EN
    .PRIO_i      (prioIn),
    .PRIO_o      (prioOut),
`endif
    .SEL_o       (sel),
    .GRANT_o     (grant),
    .BUSY_o      (busy),
    .PKT_CNT_o   (pktCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, required finish before limit");
    $fatal(1, "[TB] timeout");
  end

  // First requester after 'last' going upward with wraparound, -1 if none.
  function automatic int pickRr(input logic [15:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    mBusy = 1'b0;
    mSel  = 0;
    mLast = N - 1;
    mCnt  = '0;
    mPrio = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void modelUpdate();
    int w;
    if (!mBusy) begin
      w = -1;
`ifdef EXA_ARB_PRIO_EN
      w = pickRr(req & prioIn, mLast);
`endif
      if (w < 0) w = pickRr(req, mLast);
      if (w >= 0) begin
        mBusy = 1'b1;
        mSel  = w;
`ifdef EXA_ARB_PRIO_EN
        mPrio = prioIn[w];
`endif
      end
    end else if (muxValid && outReady && muxLast) begin
      mBusy = 1'b0;
      mLast = mSel;
      mCnt  = mCnt + 32'd1;
      mPrio = 1'b0;
    end
  endfunction

  function automatic logic [15:0] modelGrant();
    logic [15:0] one;
    one = 16'h0001;
    return mBusy ? (one << mSel) : 16'h0000;
  endfunction

  task automatic applyStimulus(input logic [15:0] r, input logic v,
                               input logic l, input logic rdy);
    req      = r;
    muxValid = v;
    muxLast  = l;
    outReady = rdy;
  endtask

  // One clock: model follows the edge, outputs are then sampled 1 unit later.
  task automatic stepCycle();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    prioIn = 16'h0000;
    reset  = 1'b1;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    resetDut();
    checks++;
    if (grant !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_grant: got %h expected %h", grant, 16'h0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (pktCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", pktCnt);
    end
    applyStimulus(16'h0001, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (sel !== 4'd0 || grant !== 16'h0001 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_grant: got sel=%0d grant=%h busy=%b expected sel=0 grant=0001 busy=1",
               sel, grant, busy);
    end
  endtask

  task automatic test_alternate();
    logic [15:0] expGrant;
    resetDut();
    for (int p = 0; p < 4; p++) begin
      expGrant = (p % 2 == 0) ? 16'h0001 : 16'h0008;
      applyStimulus(16'h0009, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checks++;
      if (grant !== expGrant || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL alt_grant%0d: got grant=%h busy=%b expected grant=%h busy=1",
                 p, grant, busy, expGrant);
      end
      for (int b = 0; b < 3; b++) begin
        applyStimulus(16'h0009, 1'b1, (b == 2), 1'b1);
        stepCycle();
      end
      checks++;
      if (grant !== 16'h0000 || busy !== 1'b0 || pktCnt !== 32'(p + 1)) begin
        errors++;
        $display("[TB] FAIL alt_bubble%0d: got grant=%h busy=%b cnt=%0d expected grant=0000 busy=0 cnt=%0d",
                 p, grant, busy, pktCnt, p + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [6:0] vPat;
    logic [6:0] rPat;
    logic [6:0] lPat;
    vPat = 7'b1101111;
    rPat = 7'b1111001;
    lPat = 7'b1010100;
    resetDut();
    applyStimulus(16'h0020, 1'b0, 1'b0, 1'b0);
    stepCycle();
    for (int c = 0; c < 7; c++) begin
      applyStimulus(16'h0020, vPat[c], lPat[c], rPat[c]);
      stepCycle();
      if (c < 6) begin
        checks++;
        if (sel !== 4'd5 || grant !== 16'h0020 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_hold%0d: got sel=%0d grant=%h busy=%b expected sel=5 grant=0020 busy=1",
                   c, sel, grant, busy);
        end
      end
    end
    checks++;
    if (grant !== 16'h0000 || busy !== 1'b0 || pktCnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL stall_release: got grant=%h busy=%b cnt=%0d expected grant=0000 busy=0 cnt=1",
               grant, busy, pktCnt);
    end
  endtask

  task automatic test_req_change();
    resetDut();
    applyStimulus(16'h0004, 1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(16'h0100, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (sel !== 4'd2 || grant !== 16'h0004 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reqchg_hold: got sel=%0d grant=%h expected sel=2 grant=0004", sel, grant);
    end
    applyStimulus(16'h0100, 1'b1, 1'b1, 1'b1);
    stepCycle();
    checks++;
    if (grant !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reqchg_release: got grant=%h busy=%b expected grant=0000 busy=0", grant, busy);
    end
    applyStimulus(16'h0100, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (sel !== 4'd8 || grant !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL reqchg_next: got sel=%0d grant=%h expected sel=8 grant=0100", sel, grant);
    end
  endtask

  task automatic test_reset_mid();
    resetDut();
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (grant !== 16'h0002 || pktCnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL rstmid_setup: got grant=%h cnt=%0d expected grant=0002 cnt=1", grant, pktCnt);
    end
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b1);
    stepCycle();
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checks++;
    if (grant !== 16'h0000 || busy !== 1'b0 || pktCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_clear: got grant=%h busy=%b cnt=%0d expected grant=0000 busy=0 cnt=0",
               grant, busy, pktCnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (sel !== 4'd0 || grant !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL rstmid_regrant: got sel=%0d grant=%h expected sel=0 grant=0001", sel, grant);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    resetDut();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h0001 << $urandom_range(0, 15);
        2:       r = 16'($urandom) & 16'($urandom);
        default: r = 16'($urandom);
      endcase
      applyStimulus(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) != 0));
      prioIn = 16'($urandom) & 16'($urandom);
      stepCycle();
      checks++;
      if (grant !== modelGrant() || busy !== mBusy || pktCnt !== mCnt) begin
        errors++;
        $display("[TB] FAIL random_c%0d: got grant=%h busy=%b cnt=%0d expected grant=%h busy=%b cnt=%0d",
                 c, grant, busy, pktCnt, modelGrant(), mBusy, mCnt);
      end
      if (mBusy) begin
        checks++;
        if (sel !== 4'(mSel)) begin
          errors++;
          $display("[TB] FAIL random_sel_c%0d: got %0d expected %0d", c, sel, mSel);
        end
      end
`ifdef EXA_ARB_PRIO_EN
      checks++;
      if (prioOut !== mPrio) begin
        errors++;
        $display("[TB] FAIL random_prio_c%0d: got %b expected %b", c, prioOut, mPrio);
      end
`endif
    end
  endtask

`ifdef EXA_ARB_PRIO_EN
  task automatic test_prio();
    resetDut();
    prioIn = 16'h0004;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(16'h0006, 1'b0, 1'b0, 1'b1);
      stepCycle();
      checks++;
      if (grant !== 16'h0004 || prioOut !== 1'b1) begin
        errors++;
        $display("[TB] FAIL prio_win%0d: got grant=%h prio=%b expected grant=0004 prio=1",
                 p, grant, prioOut);
      end
      applyStimulus(16'h0006, 1'b1, 1'b1, 1'b1);
      stepCycle();
    end
    prioIn = 16'h0000;
    applyStimulus(16'h0006, 1'b0, 1'b0, 1'b1);
    stepCycle();
    checks++;
    if (grant !== 16'h0002 || prioOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_fallback: got grant=%h prio=%b expected grant=0002 prio=0",
               grant, prioOut);
    end
  endtask
`endif

  // Scenario sequence, then the single summary line.
  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    prioIn   = 16'h0000;
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    modelReset();
    test_reset();
    test_alternate();
    test_stall();
    test_req_change();
    test_reset_mid();
`ifdef EXA_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exa_crosb_out_arbiter.md
Name: exa_crosb_out_arbiter

Overview:
- Per-output-port packet arbiter for the crossbar.
- Shares one crossbar output mux between up to input_num input ports. It selects a winner round-robin, drives the mux select and holds it for a whole packet, until the beat flagged last is accepted downstream.
- Returns per-input clear-to-send grants, so only the granted input advances its FIFO.

Parameters:
- input_num, 16, number of requesting inputs (2..32).
- sel_width, log2(input_num), width of the mux select.
- cnt_width, 32, width of the packet counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-high.
- REQ_i  input  input_num  per-input request: head-of-line packet is present and targets this output.
- MUX_VALID_i  input  1  valid of the beat currently on the mux output.
- MUX_LAST_i  input  1  last flag of the beat currently on the mux output.
- OUT_READY_i  input  1  downstream accepts a beat this cycle.
- SEL_o  output  sel_width  mux select (registered).
- GRANT_o  output  input_num  one-hot grant / CTS to inputs (registered).
- BUSY_o  output  1  a packet is locked through the mux.
- PKT_CNT_o  output  cnt_width  number of completed packets, wraps.

Behaviour:
- Reset values: SEL_o=0, GRANT_o=0, BUSY_o=0, PKT_CNT_o=0, state=IDLE, rr_ptr=input_num-1, so input 0 wins first.
- Reset assertion mid-packet clears everything immediately. No partial-packet recovery; upstream is reset too.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - If REQ_i is nonzero, the winner is the first set bit scanning from rr_ptr+1 upward, modulo input_num.
  - Next cycle: SEL_o=winner, GRANT_o=1<<winner, BUSY_o=1, state→LOCK.
  - Latency from REQ rising to GRANT: 1 cycle.
  - If REQ_i is 0, stay in IDLE and keep outputs at 0. SEL_o holds its last value; it is don't-care while GRANT_o=0.
- LOCK:
  - A transfer occurs when MUX_VALID_i & OUT_READY_i.
  - Transfer with MUX_LAST_i=1 (release):
    - next cycle GRANT_o=0, BUSY_o=0, rr_ptr=SEL_o, PKT_CNT_o+=1 (wraps at 2^cnt_width), state→IDLE.
    - One idle bubble between packets is required and intended.
  - Transfer without last: stay in LOCK.
  - No transfer: hold everything, including when MUX_VALID_i=0 mid-packet.
  - REQ_i changes are ignored while in LOCK. The granted input dropping REQ does not release the lock; only a last beat does.
- Single requester: re-granted after its bubble. A requester granted this packet has lowest priority next time among simultaneous requesters.
- A single-beat packet (last on the first beat) releases after one transfer.
- The select never changes while BUSY_o=1. This is the key invariant guaranteeing packet atomicity.
- If MUX_LAST_i is asserted without MUX_VALID_i, it is ignored.

Optional Feature:
- Macro: EXA_ARB_PRIO_EN.
- When defined:
  - Adds input PRIO_i [input_num] and output PRIO_o [1].
  - Arbitration in IDLE first considers REQ_i & PRIO_i. Round-robin applies within that set with the same rr_ptr; only if that set is empty does it fall back to all of REQ_i.
  - PRIO_o is registered with the grant and equals PRIO_i[winner]; it is reset to 0.
- When undefined: the ports are absent and arbitration is plain round-robin over REQ_i.

Decomposition:
- Shared package exa_crosb_pkg:
  - typedef arb_state_t {IDLE, LOCK};
  - localparam for default input_num, and the log2 function for sel_width.
- Sub-module exa_rr_pick:
  - Purely combinational rotate-priority-encoder (req, ptr → idx, found).
  - Instantiated once, or twice under EXA_ARB_PRIO_EN for the high-priority and all-request sets.

Test Plan:
- Reset with REQ_i=16'h0000 → GRANT_o=0, BUSY_o=0, PKT_CNT_o=0. Then REQ_i=16'h0001 → one cycle later SEL_o=0, GRANT_o=16'h0001.
- REQ_i=16'h0009 held, 3-beat packets, OUT_READY_i=1 → grants alternate 0,3,0,3. One bubble cycle between each; PKT_CNT_o increments 1..4.
- Grant to input 5, 4-beat packet, OUT_READY_i low for 2 cycles and MUX_VALID_i low for 1 cycle mid-packet → SEL_o stays 5, GRANT_o stays 16'h0020 throughout. Release only after the 4th accepted beat.
- Locked to input 2, REQ_i changes to 16'h0100 mid-packet → no change until last. Next grant is input 8.
- Reset asserted during beat 2 of a packet → same cycle GRANT_o=0, BUSY_o=0, PKT_CNT_o=0. After release with REQ_i=16'hFFFF → first grant is input 0.
- EXA_ARB_PRIO_EN defined, REQ_i=16'h0006, PRIO_i=16'h0004, single-beat packets → input 2 wins repeatedly with PRIO_o=1. Drop PRIO_i → input 1 is granted next with PRIO_o=0.
